// File: rtl/drt_enumerator_pkg.sv
// Shared types and constants for the DRT enumerator: FSM encodings, ROM layout
// (header/device word counts, word offsets) and the word-address helper.
package drt_enumerator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EMIT,
    ST_DONE,
    ST_ERROR
  } drt_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_WAIT_ACK,
    RD_RELEASE
  } rd_state_t;

  localparam logic [31:0] HDR_WORDS = 32'd4;
  localparam logic [31:0] DEV_WORDS = 32'd4;

  localparam logic [1:0] OFF_ID_VER      = 2'd0;
  localparam logic [1:0] OFF_NUM_DEV     = 2'd1;
  localparam logic [1:0] OFF_DEV_ID      = 2'd0;
  localparam logic [1:0] OFF_DEV_INFO    = 2'd1;
  localparam logic [1:0] OFF_DEV_MEM_OFF = 2'd2;
  localparam logic [1:0] OFF_DEV_SIZE    = 2'd3;

  // Header words sit at base+k; device i word k at base+4+4*i+k (wraps mod 2^32).
  function automatic logic [31:0] word_adr(input logic [31:0] base,
                                           input logic        hdr,
                                           input logic [15:0] idx,
                                           input logic [1:0]  k);
    logic [31:0] adr;
    if (hdr) adr = base + {30'd0, k};
    else     adr = base + HDR_WORDS + DEV_WORDS * {16'd0, idx} + {30'd0, k};
    return adr;
  endfunction

endpackage

// File: rtl/drt_enumerator_wb_single_read.sv
// One-word Wishbone read engine: REQ -> WAIT_ACK -> RELEASE, with optional ack
// timeout when DRT_ENUM_TIMEOUT_EN is defined.
module drt_enumerator_wb_single_read #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [31:0] adr,
  output logic        rd_done,
  output logic        rd_err,
  output logic [31:0] rd_data,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);
  import drt_enumerator_pkg::*;

  rd_state_t   state_q, state_d;
  logic [31:0] data_q;
  logic        timeout;

`ifdef DRT_ENUM_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                           to_cnt_q <= '0;
    else if (state_q == RD_REQ)        to_cnt_q <= '0;
    else if (state_q == RD_WAIT_ACK)   to_cnt_q <= to_cnt_q + 16'd1;
  end

  assign timeout = (state_q == RD_WAIT_ACK) && !wbm_ack_i && (to_cnt_q == TO_LAST);
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RD_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RD_WAIT_ACK && wbm_ack_i) data_q <= wbm_dat_i;
    end
  end

  // A held ack from the previous read keeps us in RELEASE; go may chain the next REQ.
  always_comb begin
    state_d = state_q;
    rd_done = 1'b0;
    rd_err  = 1'b0;
    case (state_q)
      RD_IDLE:     if (go) state_d = RD_REQ;
      RD_REQ:      state_d = RD_WAIT_ACK;
      RD_WAIT_ACK: begin
        if (wbm_ack_i) state_d = RD_RELEASE;
        else if (timeout) begin
          state_d = RD_IDLE;
          rd_err  = 1'b1;
        end
      end
      RD_RELEASE:  begin
        if (!wbm_ack_i) begin
          rd_done = 1'b1;
          state_d = go ? RD_REQ : RD_IDLE;
        end
      end
      default:     state_d = RD_IDLE;
    endcase
  end

  assign rd_data   = data_q;
  assign wbm_cyc_o = (state_q == RD_REQ) || (state_q == RD_WAIT_ACK);
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_we_o  = 1'b0;
  assign wbm_dat_o = '0;
  assign wbm_adr_o = wbm_cyc_o ? adr : '0;

endmodule

// File: rtl/drt_enumerator.sv
// Boot-time Device ROM Table walker: reads the header, then streams one record per
// device. Optional ack timeout enabled with `define DRT_ENUM_TIMEOUT_EN.
module drt_enumerator #(
  parameter logic [31:0] DRT_BASE_ADR   = 32'h0000_0000,
  parameter logic [15:0] EXPECTED_ID    = 16'h0001,
  parameter int          MAX_DEVICES    = 16,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] drt_version,
  output logic [15:0] num_devices,
  output logic        dev_overflow,
  output logic        dev_valid,
  input  logic        dev_ready,
  output logic [15:0] dev_index,
  output logic [31:0] dev_id,
  output logic [31:0] dev_info,
  output logic [31:0] dev_mem_off,
  output logic [31:0] dev_size,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);
  import drt_enumerator_pkg::*;

  localparam logic [15:0] MAX_D = 16'(MAX_DEVICES);

  drt_state_t  state_q, state_d;
  logic        hdr_q;
  logic [1:0]  k_q;
  logic        rd_go, rd_done, rd_err;
  logic [31:0] rd_data, rd_adr;
  logic        id_bad, count_over, last_dev;
  logic [15:0] count_clamped;

  assign rd_adr        = word_adr(DRT_BASE_ADR, hdr_q, dev_index, k_q);
  assign id_bad        = rd_data[31:16] != EXPECTED_ID;
  assign count_over    = (rd_data[31:16] != 16'd0) || (rd_data[15:0] > MAX_D);
  assign count_clamped = count_over ? MAX_D : rd_data[15:0];
  assign last_dev      = (dev_index + 16'd1) == num_devices;

  drt_enumerator_wb_single_read #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_read (
    .clk       (clk),
    .rst       (rst),
    .go        (rd_go),
    .adr       (rd_adr),
    .rd_done   (rd_done),
    .rd_err    (rd_err),
    .rd_data   (rd_data),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hdr_q        <= 1'b1;
      k_q          <= OFF_ID_VER;
      dev_index    <= '0;
      error        <= 1'b0;
      drt_version  <= '0;
      num_devices  <= '0;
      dev_overflow <= 1'b0;
      dev_id       <= '0;
      dev_info     <= '0;
      dev_mem_off  <= '0;
      dev_size     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            error        <= 1'b0;
            dev_overflow <= 1'b0;
            hdr_q        <= 1'b1;
            k_q          <= OFF_ID_VER;
            dev_index    <= '0;
          end
        end
        ST_READ: begin
          if (rd_err) error <= 1'b1;
          else if (rd_done) begin
            if (hdr_q && k_q == OFF_ID_VER) begin
              if (id_bad) error <= 1'b1;
              else begin
                drt_version <= rd_data[15:0];
                k_q         <= OFF_NUM_DEV;
              end
            end else if (hdr_q) begin
              num_devices  <= count_clamped;
              dev_overflow <= count_over;
              hdr_q        <= 1'b0;
              k_q          <= OFF_DEV_ID;
            end else begin
              case (k_q)
                OFF_DEV_ID:      dev_id      <= rd_data;
                OFF_DEV_INFO:    dev_info    <= rd_data;
                OFF_DEV_MEM_OFF: dev_mem_off <= rd_data;
                OFF_DEV_SIZE:    dev_size    <= rd_data;
                default:         ;
              endcase
              // Wraps back to word 0, ready for the next device.
              k_q <= k_q + 2'd1;
            end
          end
        end
        ST_EMIT: if (dev_ready && !last_dev) dev_index <= dev_index + 16'd1;
        default: ;
      endcase
    end
  end

  // rd_go is only raised while the engine is idle or completing a read.
  always_comb begin
    state_d = state_q;
    rd_go   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          rd_go   = 1'b1;
        end
      end
      ST_READ: begin
        if (rd_err) state_d = ST_ERROR;
        else if (rd_done) begin
          if (hdr_q && k_q == OFF_ID_VER) begin
            if (id_bad) state_d = ST_ERROR;
            else        rd_go   = 1'b1;
          end else if (hdr_q) begin
            if (count_clamped == 16'd0) state_d = ST_DONE;
            else                        rd_go   = 1'b1;
          end else if (k_q == OFF_DEV_SIZE) begin
            state_d = ST_EMIT;
          end else begin
            rd_go = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (dev_ready) begin
          if (last_dev) state_d = ST_DONE;
          else begin
            state_d = ST_READ;
            rd_go   = 1'b1;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q == ST_READ) || (state_q == ST_EMIT);
  assign done      = state_q == ST_DONE;
  assign dev_valid = state_q == ST_EMIT;

endmodule

// File: tb/tb_drt_enumerator.sv
// Directed bench for drt_enumerator with a registered-ack ROM slave model.
// Timeout steps are included when DRT_ENUM_TIMEOUT_EN is defined.
module tb_drt_enumerator;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy, done, error;
  logic [15:0] drt_version, num_devices;
  logic        dev_overflow, dev_valid, dev_ready;
  logic [15:0] dev_index;
  logic [31:0] dev_id, dev_info, dev_mem_off, dev_size;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i;

  logic [31:0] mem [0:127];
  logic        mute;
  logic        stb_prev;
  int          stb_rises, valid_cycles, done_pulses;
  int          vectors, miscompares;

  drt_enumerator #(
    .DRT_BASE_ADR   (32'h0000_0000),
    .EXPECTED_ID    (16'h0001),
    .MAX_DEVICES    (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .drt_version  (drt_version),
    .num_devices  (num_devices),
    .dev_overflow (dev_overflow),
    .dev_valid    (dev_valid),
    .dev_ready    (dev_ready),
    .dev_index    (dev_index),
    .dev_id       (dev_id),
    .dev_info     (dev_info),
    .dev_mem_off  (dev_mem_off),
    .dev_size     (dev_size),
    .wbm_cyc_o    (wbm_cyc_o),
    .wbm_stb_o    (wbm_stb_o),
    .wbm_we_o     (wbm_we_o),
    .wbm_adr_o    (wbm_adr_o),
    .wbm_dat_o    (wbm_dat_o),
    .wbm_dat_i    (wbm_dat_i),
    .wbm_ack_i    (wbm_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM slave: ack registered from stb, held until stb drops.
  always @(posedge clk) begin
    wbm_ack_i <= !mute && wbm_cyc_o && wbm_stb_o;
    wbm_dat_i <= mem[wbm_adr_o[6:0]];
  end

  always @(posedge clk) begin
    stb_prev <= wbm_stb_o;
    if (wbm_stb_o && !stb_prev) stb_rises <= stb_rises + 1;
    if (dev_valid) valid_cycles <= valid_cycles + 1;
    if (done) done_pulses <= done_pulses + 1;
  end

  function automatic logic [31:0] devWord(input int i, input int k);
    return 32'hC0DE_0000 + 32'(i * 16 + k);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic waitValid(input int limit);
    for (int i = 0; i < limit && !dev_valid; i++) step();
    checkOutput("valid_wait", {31'd0, dev_valid}, 32'd1);
  endtask

  task automatic waitIdle(input int limit);
    for (int i = 0; i < limit && busy; i++) step();
    checkOutput("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  task automatic acceptRecord();
    dev_ready = 1'b1;
    step();
    dev_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s_rise, s_valid, s_done, cyc_cnt;
    vectors = 0; miscompares = 0;
    stb_rises = 0; valid_cycles = 0; done_pulses = 0;
    stb_prev = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
    rst = 1'b1; start = 1'b0; dev_ready = 1'b0; mute = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    for (int i = 0; i < 20; i++)
      for (int k = 0; k < 4; k++) mem[4 + 4 * i + k] = devWord(i, k);
    mem[0] = 32'h0001_0001;
    mem[1] = 32'd2;

    repeat (3) step();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    checkOutput("rst_adr", wbm_adr_o, 32'd0);
    checkOutput("rst_flags", {28'd0, done, error, dev_valid, dev_overflow}, 32'd0);
    checkOutput("rst_num", {16'd0, num_devices}, 32'd0);
    rst = 1'b0;

    // Two-device ROM, first record held unaccepted for 10 cycles.
    applyStimulus();
    checkOutput("start_busy", {31'd0, busy}, 32'd1);
    checkOutput("start_stb_adr", {wbm_stb_o, wbm_adr_o[30:0]}, 32'h8000_0000);
    waitValid(100);
    checkOutput("r0_index", {16'd0, dev_index}, 32'd0);
    checkOutput("r0_id", dev_id, devWord(0, 0));
    checkOutput("r0_info", dev_info, devWord(0, 1));
    checkOutput("r0_mem_off", dev_mem_off, devWord(0, 2));
    checkOutput("r0_size", dev_size, devWord(0, 3));
    checkOutput("version", {16'd0, drt_version}, 32'd1);
    checkOutput("num_dev2", {16'd0, num_devices}, 32'd2);
    s_rise = stb_rises;
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("hold_valid_id", {dev_valid, dev_id[30:0]}, {1'b1, devWord(0, 0)});
    end
    checkOutput("hold_no_stb", 32'(stb_rises - s_rise), 32'd0);
    acceptRecord();
    checkOutput("next_req_adr", {wbm_stb_o, wbm_adr_o[30:0]}, 32'h8000_0008);
    waitValid(100);
    checkOutput("r1_index", {16'd0, dev_index}, 32'd1);
    checkOutput("r1_id", dev_id, devWord(1, 0));
    checkOutput("r1_size", dev_size, devWord(1, 3));
    acceptRecord();
    checkOutput("done_pulse", {30'd0, done, busy}, 32'd2);
    step();
    checkOutput("done_cleared", {31'd0, done}, 32'd0);

    // Header ID mismatch.
    mem[0] = 32'h0002_0001;
    s_valid = valid_cycles;
    s_rise = stb_rises;
    applyStimulus();
    waitIdle(100);
    checkOutput("id_error", {31'd0, error}, 32'd1);
    checkOutput("id_no_valid", 32'(valid_cycles - s_valid), 32'd0);
    checkOutput("id_one_read", 32'(stb_rises - s_rise), 32'd1);

    // Zero devices: restart clears error, done after two reads.
    mem[0] = 32'h0001_0001;
    mem[1] = 32'd0;
    s_rise = stb_rises;
    s_done = done_pulses;
    applyStimulus();
    checkOutput("err_cleared", {30'd0, error, busy}, 32'd1);
    waitIdle(100);
    checkOutput("zero_done", {31'd0, done}, 32'd1);
    checkOutput("zero_reads", 32'(stb_rises - s_rise), 32'd2);
    checkOutput("zero_num", {16'd0, num_devices}, 32'd0);
    step();
    checkOutput("zero_done_count", 32'(done_pulses - s_done), 32'd1);

    // Count 20 clamps to 16 records with overflow.
    mem[1] = 32'd20;
    s_rise = stb_rises;
    applyStimulus();
    for (int i = 0; i < 16; i++) begin
      waitValid(100);
      checkOutput("ovf_index", {16'd0, dev_index}, 32'(i));
      checkOutput("ovf_id", dev_id, devWord(i, 0));
      checkOutput("ovf_size", dev_size, devWord(i, 3));
      acceptRecord();
    end
    checkOutput("ovf_done", {31'd0, done}, 32'd1);
    checkOutput("ovf_flag", {31'd0, dev_overflow}, 32'd1);
    checkOutput("ovf_num", {16'd0, num_devices}, 32'd16);
    checkOutput("ovf_reads", 32'(stb_rises - s_rise), 32'd66);

`ifdef DRT_ENUM_TIMEOUT_EN
    // Silent slave: one REQ cycle plus 8 wait cycles, then error.
    mute = 1'b1;
    applyStimulus();
    cyc_cnt = 0;
    for (int i = 0; i < 40 && wbm_cyc_o; i++) begin
      cyc_cnt++;
      step();
    end
    checkOutput("to_cyc_cycles", 32'(cyc_cnt), 32'd9);
    checkOutput("to_error", {30'd0, error, busy}, 32'd2);
    mute = 1'b0;
`else
    cyc_cnt = 0;
`endif

    // Reset during device-1 WAIT_ACK.
    mem[1] = 32'd2;
    applyStimulus();
    waitValid(100);
    acceptRecord();
    checkOutput("mid_req", {wbm_stb_o, wbm_adr_o[30:0]}, 32'h8000_0008);
    step();
    checkOutput("mid_wait_stb", {31'd0, wbm_stb_o}, 32'd1);
    rst = 1'b1;
    step();
    checkOutput("mid_rst_bus", {29'd0, wbm_cyc_o, wbm_stb_o, busy}, 32'd0);
    checkOutput("mid_rst_regs", {dev_valid, 15'd0, num_devices | dev_id[15:0]}, 32'd0);
    rst = 1'b0;
    s_rise = stb_rises;
    s_valid = valid_cycles;
    repeat (6) step();
    checkOutput("mid_no_restart", 32'(stb_rises - s_rise), 32'd0);
    checkOutput("mid_no_valid", 32'(valid_cycles - s_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
